mux_2a1_reorden: RTL

//  Recombines the two lanes produced by the 1:2 demux into one byte stream, in the original order.

---
 rtl/mux_2a1_reorden_pkg.sv | 13 +
 rtl/mux_2a1_reorden_fifo_lane.sv | 72 +++++++
 rtl/mux_2a1_reorden.sv | 109 ++++++++++
 3 files changed

// File: rtl/mux_2a1_reorden_pkg.sv
// Shared types and defaults for the 2:1 lane recombiner.
// Selector encodings and default widths live here.
package mux_2a1_reorden_pkg;

    localparam int DATA_W_DEF     = 8;
    localparam int FIFO_DEPTH_DEF = 4;

    typedef enum logic {
        SEL0 = 1'b0,
        SEL1 = 1'b1
    } sel_e;

endpackage

// File: rtl/mux_2a1_reorden_fifo_lane.sv
// Per-lane synchronous FIFO with free-running push side.
// A push on a full lane is dropped unless the same edge pops.
module mux_2a1_reorden_fifo_lane #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty,
    output logic              drop
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              pop_ok;
    logic              accept;

    assign full  = (count_q == (PTR_W+1)'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    // Next pointer/count/storage; a pop frees the slot a full push needs.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        pop_ok   = pop && !empty;
        accept   = push && (!full || pop_ok);
        drop     = push && full && !pop_ok;
        if (accept) begin
            mem_d[wr_ptr_q] = data_in;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (accept && !pop_ok) begin
            count_d = count_q + (PTR_W+1)'(1);
        end else if (pop_ok && !accept) begin
            count_d = count_q - (PTR_W+1)'(1);
        end
    end

    // FIFO state registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/mux_2a1_reorden.sv
// Recombines two demuxed lanes into one stream, strictly lane0, lane1, ...
// Each lane is buffered; an alternating selector drains into a registered output.
module mux_2a1_reorden
    import mux_2a1_reorden_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in0,
    input  logic              valid_in0,
    input  logic [DATA_W-1:0] data_in1,
    input  logic              valid_in1,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              full0,
    output logic              full1,
    output logic              overflow_err
);

    sel_e              sel_q, sel_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              valid_out_q, valid_out_d;
    logic              overflow_q, overflow_d;
    logic [DATA_W-1:0] head0, head1;
    logic              empty0, empty1;
    logic              drop0, drop1;
    logic              pop0, pop1;

    mux_2a1_reorden_fifo_lane #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_lane0 (
        .clk     (clk),
        .reset   (reset),
        .push    (valid_in0),
        .pop     (pop0),
        .data_in (data_in0),
        .head    (head0),
        .full    (full0),
        .empty   (empty0),
        .drop    (drop0)
    );

    mux_2a1_reorden_fifo_lane #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_lane1 (
        .clk     (clk),
        .reset   (reset),
        .push    (valid_in1),
        .pop     (pop1),
        .data_in (data_in1),
        .head    (head1),
        .full    (full1),
        .empty   (empty1),
        .drop    (drop1)
    );

    // Selector: wait on the expected lane, never skip it.
    always_comb begin
        sel_d       = sel_q;
        data_out_d  = data_out_q;
        valid_out_d = 1'b0;
        pop0        = 1'b0;
        pop1        = 1'b0;
        overflow_d  = overflow_q | drop0 | drop1;
        unique case (sel_q)
            SEL0: begin
                if (!empty0) begin
                    pop0        = 1'b1;
                    data_out_d  = head0;
                    valid_out_d = 1'b1;
                    sel_d       = SEL1;
                end
            end
            SEL1: begin
                if (!empty1) begin
                    pop1        = 1'b1;
                    data_out_d  = head1;
                    valid_out_d = 1'b1;
                    sel_d       = SEL0;
                end
            end
            default: sel_d = SEL0;
        endcase
    end

    // Selector state, output register and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q       <= SEL0;
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            sel_q       <= sel_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
            overflow_q  <= overflow_d;
        end
    end

    assign data_out     = data_out_q;
    assign valid_out    = valid_out_q;
    assign overflow_err = overflow_q;

endmodule
